// File: rtl/operand_forward.sv
// operand_forward: EX-entry operand bypass with EX/MEM/WB destination tracking
module operand_forward #(
  parameter int WIDTH = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_register_write,
  input  logic                id_is_load,
  input  logic [WIDTH-1:0]    register_1,
  input  logic [WIDTH-1:0]    register_2,
  input  logic [WIDTH-1:0]    ex_result,
  input  logic [WIDTH-1:0]    mem_result,
  output logic                forwarding_rs,
  output logic                forwarding_rt,
  output logic                load_use_stall,
  output logic [WIDTH-1:0]    operand_a,
  output logic [WIDTH-1:0]    operand_b,
  output logic                ex_valid,
  output logic [REG_BITS-1:0] ex_rd,
  output logic                ex_register_write,
  output logic [REG_BITS-1:0] rd_wb,
  output logic [WIDTH-1:0]    result
);
  logic                ex_v_q, ex_wr_q, ex_ld_q, ex_v_d, ex_wr_d, ex_ld_d;
  logic [REG_BITS-1:0] ex_rd_q, ex_rd_d;
  logic                mem_v_q, mem_wr_q, mem_ld_q, mem_v_d, mem_wr_d, mem_ld_d;
  logic [REG_BITS-1:0] mem_rd_q, mem_rd_d;
  logic [WIDTH-1:0]    mem_data_q, mem_data_d;
  logic                wb_v_q, wb_wr_q, wb_v_d, wb_wr_d;
  logic [REG_BITS-1:0] wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0]    wb_data_q, wb_data_d;
  logic [WIDTH-1:0]    opa_q, opb_q, opa_d, opb_d;
  logic [REG_BITS-1:0] src [2];
  logic [WIDTH-1:0]    rf [2];
  logic [WIDTH-1:0]    val [2];
  logic [1:0]          exh, memh, wbh, dep, fwd;
  logic [WIDTH-1:0]    mem_fwd;
  logic                take;

  assign src[0] = id_rs;
  assign src[1] = id_rt;
  assign rf[0] = register_1;
  assign rf[1] = register_2;
  assign mem_fwd = mem_ld_q ? mem_result : mem_data_q;

  for (genvar i = 0; i < 2; i++) begin : g_src
    assign exh[i]  = src[i] != '0 && ex_v_q && ex_wr_q && ex_rd_q == src[i];
    assign memh[i] = src[i] != '0 && mem_v_q && mem_wr_q && mem_rd_q == src[i];
    assign wbh[i]  = src[i] != '0 && wb_v_q && wb_wr_q && wb_rd_q == src[i];
    assign dep[i]  = exh[i] && ex_ld_q;
    assign fwd[i]  = id_valid && !dep[i] && (exh[i] || memh[i] || wbh[i]);
    assign val[i]  = src[i] == '0 ? '0 : exh[i] ? ex_result : memh[i] ? mem_fwd :
                     wbh[i] ? wb_data_q : rf[i];
  end

  assign forwarding_rs = fwd[0];
  assign forwarding_rt = fwd[1];
  assign load_use_stall = id_valid && |dep;
  assign take = id_valid && !flush && !load_use_stall;

  // Next state: slots shift unless stalled; EX takes the ID entry or a bubble
  always_comb begin
    ex_v_d = ex_v_q;
    ex_rd_d = ex_rd_q;
    ex_wr_d = ex_wr_q;
    ex_ld_d = ex_ld_q;
    mem_v_d = mem_v_q;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
    mem_ld_d = mem_ld_q;
    mem_data_d = mem_data_q;
    wb_v_d = wb_v_q;
    wb_rd_d = wb_rd_q;
    wb_wr_d = wb_wr_q;
    wb_data_d = wb_data_q;
    opa_d = opa_q;
    opb_d = opb_q;
    if (!stall) begin
      wb_v_d = mem_v_q;
      wb_rd_d = mem_rd_q;
      wb_wr_d = mem_wr_q;
      wb_data_d = mem_fwd;
      mem_v_d = ex_v_q;
      mem_rd_d = ex_rd_q;
      mem_wr_d = ex_wr_q;
      mem_ld_d = ex_ld_q;
      mem_data_d = ex_result;
    end
    if (!stall || flush) begin
      ex_v_d = take;
      ex_rd_d = take ? id_rd : '0;
      ex_wr_d = take && id_register_write;
      ex_ld_d = take && id_is_load;
      opa_d = take ? val[0] : '0;
      opb_d = take ? val[1] : '0;
    end
  end

  // Slot and operand registers, cleared immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q <= 1'b0;
      ex_rd_q <= '0;
      ex_wr_q <= 1'b0;
      ex_ld_q <= 1'b0;
      mem_v_q <= 1'b0;
      mem_rd_q <= '0;
      mem_wr_q <= 1'b0;
      mem_ld_q <= 1'b0;
      mem_data_q <= '0;
      wb_v_q <= 1'b0;
      wb_rd_q <= '0;
      wb_wr_q <= 1'b0;
      wb_data_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else begin
      ex_v_q <= ex_v_d;
      ex_rd_q <= ex_rd_d;
      ex_wr_q <= ex_wr_d;
      ex_ld_q <= ex_ld_d;
      mem_v_q <= mem_v_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      mem_ld_q <= mem_ld_d;
      mem_data_q <= mem_data_d;
      wb_v_q <= wb_v_d;
      wb_rd_q <= wb_rd_d;
      wb_wr_q <= wb_wr_d;
      wb_data_q <= wb_data_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
    end
  end

  assign operand_a = opa_q;
  assign operand_b = opb_q;
  assign ex_valid = ex_v_q;
  assign ex_rd = ex_rd_q;
  assign ex_register_write = ex_wr_q;
  assign rd_wb = wb_v_q && wb_wr_q ? wb_rd_q : '0;
  assign result = wb_data_q;
endmodule

// File: doc/operand_forward.md
# operand_forward

Execute-entry operand stage of the MIPS core, downstream of the register file. Tracks the destinations of the three youngest in-flight instructions (EX, MEM, WB slots). From these it selects each ALU operand from either the register-file read data or a bypassed result. It tells the register file which source registers it can bypass, so the register file can skip its lock stall. It also retires the WB slot to the register file as `rd_wb`/`result`.

## Interface
- `WIDTH`, 32, datapath width
- `REG_BITS`, 5, register index width
- `clk` in 1: single clock; all state updates on rising edge
- `rst_n` in 1: asynchronous active-low reset
- `stall` in 1: global pipeline hold
- `flush` in 1: kill the instruction entering EX this cycle
- `id_valid` in 1: decode presents an instruction
- `id_rs`, `id_rt`, `id_rd` in REG_BITS: source and destination indices
- `id_register_write` in 1: instruction writes `id_rd`
- `id_is_load` in 1: instruction's result is produced in MEM
- `register_1`, `register_2` in WIDTH: register-file read data for rs and rt
- `ex_result` in WIDTH: ALU result of the EX-slot instruction (combinational)
- `mem_result` in WIDTH: load data of the MEM-slot instruction (combinational)
- `forwarding_rs`, `forwarding_rt` out 1: source is bypassable this cycle (combinational)
- `load_use_stall` out 1: source depends on the load in EX (combinational)
- `operand_a`, `operand_b` out WIDTH: registered ALU operands
- `ex_valid`, `ex_rd`, `ex_register_write` out 1/REG_BITS/1: EX slot contents
- `rd_wb` out REG_BITS, `result` out WIDTH: registered writeback to the register file

## Operation
- Each slot holds {valid, rd, wr, load, data}. `data` is meaningful in MEM and WB only.
- A slot *hits* source s when: s≠0, valid, wr, and rd==s.
- Bypass value per source, youngest hit wins:
  - EX hit, non-load: `ex_result`.
  - EX hit, load: no value; `load_use_stall`=1.
  - MEM hit: load ? `mem_result` : MEM.data.
  - WB hit: WB.data.
  - No hit: `register_1`/`register_2`.
  - s==0 always yields 0.
- `forwarding_rs` = id_valid ∧ rs hit in any slot ∧ the youngest hit is not an EX load. `forwarding_rt` is defined the same way for rt.
- `load_use_stall` = id_valid ∧ (rs or rt youngest hit is an EX load).
- Advance, when `stall`=0:
  - WB ← MEM. WB.data ← MEM.load ? `mem_result` : MEM.data.
  - MEM ← EX. MEM.data ← `ex_result`.
  - EX ← ID entry when id_valid ∧ ¬flush ∧ ¬load_use_stall; otherwise EX ← bubble (valid=0).
  - `operand_a`/`operand_b` ← the selected values; they are set to 0 when a bubble is inserted.
- `flush` with `stall`: EX ← bubble; MEM and WB hold.
- `stall` without `flush`: every register holds.
- `rd_wb` = WB.valid ∧ WB.wr ? WB.rd : 0. `result` = WB.data. An `rd_wb` of 0 is a no-op at the register file.

## Timing
- Reset (async, immediate): all slots invalid; `rd`=0, `data`=0. `operand_a`, `operand_b`, `rd_wb`, `result`, `ex_rd` are 0. `ex_valid` and `ex_register_write` are 0.
- Combinational outputs depend only on the current `id_*`, the slots, and the result inputs. They are valid once reset deasserts.
- Latency:
  - ID → EX slot: 1 cycle.
  - EX → `rd_wb` visible: 2 cycles.
  - Load-use costs exactly one bubble. After the bubble the load sits in MEM and is bypassed from `mem_result`.
- Same rd in several slots: the youngest wins, so no stale value is bypassed.
- Writes to r0 never hit and never appear on `rd_wb`.
- A reset that deasserts between edges loses in-flight slots. Upstream must restart fetch.

## Test plan
- Reset while slots are full (rst_n low mid-cycle) -> all outputs 0 immediately; `forwarding_*`=0.
- Back-to-back ALU dependency:
  - add r3 (ex_result=0x10) then rs=3 with register_1=0xDEAD -> `forwarding_rs`=1.
  - Next edge: `operand_a`=0x10.
- Load-use:
  - lw r5 in EX, then id rt=5 -> `load_use_stall`=1; EX becomes a bubble.
  - Next cycle: `mem_result`=0x1234 -> `operand_b`=0x1234, `load_use_stall`=0.
- Priority: r7 written in WB (0x1), MEM (0x2), EX (0x3), then rs=rt=7 -> both operands 0x3.
- r0 and flush:
  - id_rd=0 write, then rs=0 -> `operand_a`=0 and `rd_wb`=0 two cycles later.
  - flush=1 with id_valid -> `ex_valid`=0 next edge.
- Stall hold: `stall`=1 for 3 cycles with varying `ex_result` -> all registered outputs unchanged.
- Stall release: after `stall` drops, WB.data equals the MEM.data latched before the stall.
